key_click_decoder: RTL and testbench

Downstream stage of the key debounce block: consumes its three one-cycle key press pulses and classifies each press sequence as a single click or a double click, using a configurable double-click window. Decided clicks are emitted as per-key pulses and queued into a one-deep valid/ready event register for the menu/control logic. All logic runs on the system clock; a shared prescaler provides the millisecond timebase.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_click_chan.sv | 61 ++++++
 rtl/key_click_decoder.sv | 117 +++++++++++
 tb/tb_key_click_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key click decoder: channel count, event code
// layout and the per-key FSM state type.
package key_pkg;

    localparam int unsigned KEY_NUM     = 3;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned WIN_W       = 10;
    localparam int unsigned EVT_DBL_BIT = 2;
    localparam int unsigned EVT_IDX_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_e;

endpackage

// File: rtl/key_click_chan.sv
// One key's click classifier: opens a window on the first press and decides
// single (window expires) or double (second press inside the window).
module key_click_chan
    import key_pkg::*;
#(
    parameter int unsigned DBL_WIN_MS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic key_pulse,
    input  logic tick,
    output logic dec_single,
    output logic dec_double
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(DBL_WIN_MS - 1);

    chan_state_e      state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        dec_single = 1'b0;
        dec_double = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_pulse) begin
                    state_d   = WAIT;
                    win_cnt_d = '0;
                end
            end
            WAIT: begin
                // A press on the timeout edge still counts as the second click.
                if (key_pulse) begin
                    dec_double = 1'b1;
                    state_d    = IDLE;
                end else if (tick) begin
                    if (win_cnt_q == WIN_LAST) begin
                        dec_single = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
        end
    end

endmodule

// File: rtl/key_click_decoder.sv
// Classifies debounced key presses into single/double clicks and queues the
// decisions into a one-deep valid/ready event register.
module key_click_decoder
    import key_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000,
    parameter int unsigned DBL_WIN_MS = 250
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_pulse,
    output logic [KEY_NUM-1:0] single_click,
    output logic [KEY_NUM-1:0] double_click,
    output logic               event_valid,
    output logic [2:0]         event_code,
    input  logic               event_ready,
    output logic               overflow
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0]      presc_q, presc_d;
    logic               tick;
    logic [KEY_NUM-1:0] dec_s, dec_d, dec_any, avail;
    logic [KEY_NUM-1:0] pending_q, pending_d, pend_dbl_q, pend_dbl_d;
    logic               event_valid_q, event_valid_d, overflow_q, overflow_d;
    logic [2:0]         event_code_q, event_code_d;
    logic               load_en, found;
    logic [IDX_W-1:0]   sel;

    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
        key_click_chan #(.DBL_WIN_MS(DBL_WIN_MS)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .key_pulse  (key_pulse[i]),
            .tick       (tick),
            .dec_single (dec_s[i]),
            .dec_double (dec_d[i])
        );
    end

    // Fresh decisions join the pending set so an empty register loads them at once.
    always_comb begin
        dec_any       = dec_s | dec_d;
        avail         = pending_q | dec_any;
        load_en       = !event_valid_q || event_ready;
        found         = 1'b0;
        sel           = '0;
        pending_d     = pending_q;
        pend_dbl_d    = pend_dbl_q;
        event_valid_d = event_valid_q;
        event_code_d  = event_code_q;
        overflow_d    = overflow_q;

        for (int unsigned i = 0; i < KEY_NUM; i++) begin
            if (!found && avail[i]) begin
                found = 1'b1;
                sel   = IDX_W'(i);
            end
        end

        if (load_en) begin
            event_valid_d = found;
            if (found) begin
                event_code_d[EVT_DBL_BIT]            = pending_q[sel] ? pend_dbl_q[sel] : dec_d[sel];
                event_code_d[EVT_IDX_LSB +: IDX_W]   = sel;
            end
        end

        for (int unsigned i = 0; i < KEY_NUM; i++) begin
            if (load_en && found && (sel == IDX_W'(i))) begin
                // Old entry leaves; a same-cycle decision refills the slot.
                pending_d[i] = pending_q[i] && dec_any[i];
                if (pending_q[i] && dec_any[i]) pend_dbl_d[i] = dec_d[i];
            end else if (dec_any[i]) begin
                if (pending_q[i]) begin
                    overflow_d = 1'b1;
                end else begin
                    pending_d[i]  = 1'b1;
                    pend_dbl_d[i] = dec_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            pending_q     <= '0;
            pend_dbl_q    <= '0;
            event_valid_q <= 1'b0;
            event_code_q  <= '0;
            overflow_q    <= 1'b0;
            single_click  <= '0;
            double_click  <= '0;
        end else begin
            presc_q       <= presc_d;
            pending_q     <= pending_d;
            pend_dbl_q    <= pend_dbl_d;
            event_valid_q <= event_valid_d;
            event_code_q  <= event_code_d;
            overflow_q    <= overflow_d;
            single_click  <= dec_s;
            double_click  <= dec_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_code  = event_code_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Bench for key_click_decoder: table of click sequences plus hand-written
// corner cases; accepted events are checked against a queue of expected codes.
module tb_key_click_decoder;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned DBL_WIN_MS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_pulse = '0;
    logic       event_ready = 1'b0;
    logic [2:0] single_click, double_click, event_code;
    logic       event_valid, overflow;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ecnt;
    int unsigned single_cnt [3] = '{0, 0, 0};
    int unsigned double_cnt [3] = '{0, 0, 0};
    logic [2:0]  exp_q [$];

    typedef struct {
        int unsigned key;
        int unsigned gap;
        logic [2:0]  code;
        int unsigned n_single;
        int unsigned n_double;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    key_click_decoder #(.TICK_DIV(TICK_DIV), .DBL_WIN_MS(DBL_WIN_MS)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pulse    (key_pulse),
        .single_click (single_click),
        .double_click (double_click),
        .event_valid  (event_valid),
        .event_code   (event_code),
        .event_ready  (event_ready),
        .overflow     (overflow)
    );

    // Index of the next rising edge; the prescaler sees count ecnt % TICK_DIV there.
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                single_cnt[i] <= single_cnt[i] + 32'(single_click[i]);
                double_cnt[i] <= double_cnt[i] + 32'(double_click[i]);
            end
            if (event_valid && event_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL event_extra: got code %b with none expected", event_code);
                end else begin
                    check("event_code", {29'b0, event_code}, {29'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] k);
        key_pulse = k;
        step(1);
        key_pulse = '0;
    endtask

    // Edge on which a window opened by a press captured at edge cap expires.
    function automatic int unsigned timeout_edge(input int unsigned cap);
        int unsigned first = cap + 1;
        while (first % TICK_DIV != TICK_DIV - 1) first++;
        return first + (DBL_WIN_MS - 1) * TICK_DIV;
    endfunction

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        check(name, exp_q.size(), 0);
    endtask

    task automatic single_exact(input int unsigned k, input string name);
        int unsigned cap, t_edge, s0, d0;
        s0 = single_cnt[k];
        d0 = double_cnt[k];
        exp_q.push_back({1'b0, 2'(k)});
        cap = ecnt;
        pulse(3'(1 << k));
        t_edge = timeout_edge(cap);
        while (ecnt < t_edge) step(1);
        check({name, "_early"}, single_click[k], 0);
        step(1);
        check({name, "_pulse"}, single_click[k], 1);
        check({name, "_valid"}, event_valid, 1);
        check({name, "_code"}, event_code, {1'b0, 2'(k)});
        step(1);
        check({name, "_one_cycle"}, single_click[k], 0);
        step(4);
        check({name, "_n_single"}, single_cnt[k] - s0, 1);
        check({name, "_n_double"}, double_cnt[k] - d0, 0);
        drain({name, "_drain"});
    endtask

    initial begin
        int unsigned cap, t_edge;
        int unsigned s0 [3];
        int unsigned d0 [3];

        vecs[0] = '{0, 0, 3'b000, 1, 0};
        vecs[1] = '{1, 5, 3'b101, 0, 1};
        vecs[2] = '{2, 1, 3'b110, 0, 1};
        vecs[3] = '{0, 8, 3'b100, 0, 1};
        vecs[4] = '{2, 0, 3'b010, 1, 0};
        vecs[5] = '{1, 0, 3'b001, 1, 0};

        step(3);
        check("rst_single", single_click, 0);
        check("rst_double", double_click, 0);
        check("rst_valid", event_valid, 0);
        check("rst_code", event_code, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        step(2);

        event_ready = 1'b1;
        single_exact(0, "single0");

        for (int v = 0; v < 6; v++) begin
            s0[0] = single_cnt[vecs[v].key];
            d0[0] = double_cnt[vecs[v].key];
            exp_q.push_back(vecs[v].code);
            pulse(3'(1 << vecs[v].key));
            if (vecs[v].gap > 0) begin
                step(vecs[v].gap - 1);
                pulse(3'(1 << vecs[v].key));
            end
            step(16);
            check($sformatf("vec%0d_single", v), single_cnt[vecs[v].key] - s0[0], vecs[v].n_single);
            check($sformatf("vec%0d_double", v), double_cnt[vecs[v].key] - d0[0], vecs[v].n_double);
            drain($sformatf("vec%0d_drain", v));
        end

        // Two timeouts on one edge with the consumer stalled.
        event_ready = 1'b0;
        s0[0] = single_cnt[0];
        s0[2] = single_cnt[2];
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b010);
        cap = ecnt;
        pulse(3'b101);
        t_edge = timeout_edge(cap);
        while (ecnt < t_edge + 1) step(1);
        check("simul_valid", event_valid, 1);
        check("simul_code0", event_code, 3'b000);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("simul_hold", {event_valid, event_code}, 4'b1000);
        end
        event_ready = 1'b1;
        step(1);
        check("simul_code1", {event_valid, event_code}, 4'b1010);
        step(1);
        check("simul_empty", event_valid, 0);
        check("simul_n_single0", single_cnt[0] - s0[0], 1);
        check("simul_n_single2", single_cnt[2] - s0[2], 1);
        drain("simul_drain");

        // Second press captured on the exact timeout edge.
        s0[1] = single_cnt[1];
        d0[1] = double_cnt[1];
        exp_q.push_back(3'b101);
        cap = ecnt;
        pulse(3'b010);
        t_edge = timeout_edge(cap);
        while (ecnt < t_edge) step(1);
        pulse(3'b010);
        step(16);
        check("race_single", single_cnt[1] - s0[1], 0);
        check("race_double", double_cnt[1] - d0[1], 1);
        drain("race_drain");

        // Three singles on key2 with no consumer: register, pending, dropped.
        event_ready = 1'b0;
        s0[2] = single_cnt[2];
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b010);
        for (int i = 0; i < 3; i++) begin
            pulse(3'b100);
            step(16);
            check($sformatf("ovf_flag%0d", i), overflow, (i == 2) ? 1 : 0);
        end
        check("ovf_n_single", single_cnt[2] - s0[2], 3);
        event_ready = 1'b1;
        step(3);
        drain("ovf_drain");
        check("ovf_empty", event_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset while key0 is mid-window.
        s0[0] = single_cnt[0];
        d0[0] = double_cnt[0];
        pulse(3'b001);
        step(4);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {single_click, double_click, event_valid, event_code, overflow}, 0);
        step(2);
        rst = 1'b0;
        step(16);
        check("mid_rst_no_single", single_cnt[0] - s0[0], 0);
        check("mid_rst_no_double", double_cnt[0] - d0[0], 0);
        check("mid_rst_no_event", exp_q.size(), 0);
        single_exact(0, "after_rst");

        drain("final_drain");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
